// File: rtl/digest_matcher.sv
// Pairs in-order digests from the pancham hash core with queued candidates and flags a target match.
// Optional build macro MATCHER_MULTI_HIT_EN: keep searching after a match and count hits on hit_count.
module digest_matcher #(
  parameter int MSG_W  = 128,
  parameter int HASH_W = 128,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [HASH_W-1:0]         target_in,
  input  logic                      target_load,
  input  logic [MSG_W-1:0]          cand_in,
  input  logic                      cand_valid,
  output logic                      cand_ready,
  input  logic [HASH_W-1:0]         dig_in,
  input  logic                      dig_valid,
  output logic                      armed,
  output logic                      found,
  output logic [MSG_W-1:0]          found_msg,
  output logic                      stop,
  output logic [CNT_W-1:0]          tried_count,
  output logic                      underflow_err,
`ifdef MATCHER_MULTI_HIT_EN
  output logic [CNT_W-1:0]          hit_count,
`endif
  output logic [1:0]                fsm_state,
  output logic [$clog2(DEPTH):0]    fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FOUND = 2'd2
  } state_t;

  state_t            state;
  logic [HASH_W-1:0] target;
  logic [MSG_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              compare;

  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);

  // Handshake: a candidate is taken on any cycle with cand_valid && cand_ready, where
  // cand_ready = !full && ARMED. When full, a candidate offered in the same cycle as a
  // digest pop is also taken, since the pop frees the slot; target_load discards both.
  assign cand_ready = !full && (state == S_ARMED);
  assign push       = cand_valid && (state == S_ARMED) && (!full || (dig_valid && !empty))
                      && !target_load;
  assign pop        = dig_valid && !empty && !target_load;
  assign compare    = pop && (state == S_ARMED);

  assign armed      = (state == S_ARMED);
  assign stop       = (state == S_FOUND);
  assign fsm_state  = state;
  assign fill_level = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cand_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      target        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      found         <= 1'b0;
      found_msg     <= '0;
      tried_count   <= '0;
      underflow_err <= 1'b0;
`ifdef MATCHER_MULTI_HIT_EN
      hit_count     <= '0;
`endif
    end else if (target_load) begin
      state         <= S_ARMED;
      target        <= target_in;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      found         <= 1'b0;
      found_msg     <= '0;
      tried_count   <= '0;
      underflow_err <= 1'b0;
`ifdef MATCHER_MULTI_HIT_EN
      hit_count     <= '0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // An empty FIFO never forwards a same-cycle push to the digest.
      if (dig_valid && empty) underflow_err <= 1'b1;
      if (compare) begin
        if (tried_count != '1) tried_count <= tried_count + 1'b1;
        if (dig_in == target) begin
          found     <= 1'b1;
          found_msg <= mem[rd_ptr];
`ifdef MATCHER_MULTI_HIT_EN
          if (hit_count != '1) hit_count <= hit_count + 1'b1;
`else
          state     <= S_FOUND;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_digest_matcher.sv
// Bench for digest_matcher: directed scenarios plus random traffic against a queue-based model.
module tb_digest_matcher;

  localparam int DEPTH = 8;
  localparam logic [127:0] TGT = 128'h13aad5860139a22c6dd6d1304a2a0ec9;
  localparam logic [127:0] TGT2 = 128'h0123456789abcdef0fedcba987654321;

  logic         clk;
  logic         reset;
  logic [127:0] target_in;
  logic         target_load;
  logic [127:0] cand_in;
  logic         cand_valid;
  logic         cand_ready;
  logic [127:0] dig_in;
  logic         dig_valid;
  logic         armed;
  logic         found;
  logic [127:0] found_msg;
  logic         stop;
  logic [31:0]  tried_count;
  logic         underflow_err;
  logic [31:0]  hit_count;
  logic [1:0]   fsm_state;
  logic [3:0]   fill_level;

  digest_matcher #(.MSG_W(128), .HASH_W(128), .DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .target_in(target_in), .target_load(target_load),
    .cand_in(cand_in), .cand_valid(cand_valid), .cand_ready(cand_ready),
    .dig_in(dig_in), .dig_valid(dig_valid), .armed(armed), .found(found),
    .found_msg(found_msg), .stop(stop), .tried_count(tried_count),
    .underflow_err(underflow_err),
`ifdef MATCHER_MULTI_HIT_EN
    .hit_count(hit_count),
`endif
    .fsm_state(fsm_state), .fill_level(fill_level)
  );

`ifndef MATCHER_MULTI_HIT_EN
  assign hit_count = '0;
`endif

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         armed;
    logic         found;
    logic         stop;
    logic         ready;
    logic         uf;
    logic [127:0] msg;
    logic [31:0]  tried;
    logic [3:0]   fill;
    logic [31:0]  hits;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // reference model: search status plus the list of outstanding candidates
  logic [127:0] m_fifo[$];
  logic [127:0] m_target = '0;
  logic         m_search = 1'b0;
  logic         m_hit_stop = 1'b0;
  logic         m_found = 1'b0;
  logic [127:0] m_msg = '0;
  int unsigned  m_tried = 0;
  logic         m_uf = 1'b0;
  int unsigned  m_hits = 0;

  task automatic model_step(input logic rst, input logic tl, input logic [127:0] tin,
                            input logic cv, input logic [127:0] c,
                            input logic dv, input logic [127:0] d);
    logic [127:0] head;
    logic popped;
    popped = 1'b0;
    if (rst) begin
      m_fifo.delete(); m_target = '0; m_search = 0; m_hit_stop = 0;
      m_found = 0; m_msg = '0; m_tried = 0; m_uf = 0; m_hits = 0;
    end else if (tl) begin
      m_fifo.delete(); m_target = tin; m_search = 1; m_hit_stop = 0;
      m_found = 0; m_msg = '0; m_tried = 0; m_uf = 0; m_hits = 0;
    end else begin
      logic searching;
      searching = m_search;
      if (dv && m_fifo.size() > 0) begin
        head = m_fifo.pop_front();
        popped = 1'b1;
        if (searching) begin
          m_tried++;
          if (d == m_target) begin
            m_found = 1; m_msg = head; m_hits++;
`ifndef MATCHER_MULTI_HIT_EN
            m_search = 0; m_hit_stop = 1;
`endif
          end
        end
      end else if (dv) begin
        m_uf = 1;
      end
      // room is judged after this cycle's pop
      if (cv && searching && m_fifo.size() < DEPTH) m_fifo.push_back(c);
    end
    if (popped) head = '0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.armed = m_search;
    o.found = m_found;
    o.stop  = m_hit_stop;
    o.ready = m_search && (m_fifo.size() < DEPTH);
    o.uf    = m_uf;
    o.msg   = m_msg;
    o.tried = m_tried;
    o.fill  = 4'(m_fifo.size());
    o.hits  = m_hits;
    return o;
  endfunction

  // driver task: one clock cycle of inputs
  task automatic cyc(input logic rst, input logic tl, input logic [127:0] tin,
                     input logic cv, input logic [127:0] c,
                     input logic dv, input logic [127:0] d);
    reset = rst; target_load = tl; target_in = tin;
    cand_valid = cv; cand_in = c; dig_valid = dv; dig_in = d;
    model_step(rst, tl, tin, cv, c, dv, d);
    @(posedge clk);
    exp_q.push_back(model_obs());
    #1;
    reset = 0; target_load = 0; cand_valid = 0; dig_valid = 0;
  endtask

  task automatic idle();
    cyc(0, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic push(input logic [127:0] c);
    cyc(0, 0, '0, 1, c, 0, '0);
  endtask

  task automatic dig(input logic [127:0] d);
    cyc(0, 0, '0, 0, '0, 1, d);
  endtask

  task automatic load(input logic [127:0] t);
    cyc(0, 1, t, 0, '0, 0, '0);
  endtask

  // scoreboard
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      chk("armed",         128'(armed),         128'(e.armed));
      chk("found",         128'(found),         128'(e.found));
      chk("stop",          128'(stop),          128'(e.stop));
      chk("cand_ready",    128'(cand_ready),    128'(e.ready));
      chk("underflow_err", 128'(underflow_err), 128'(e.uf));
      chk("found_msg",     found_msg,           e.msg);
      chk("tried_count",   128'(tried_count),   128'(e.tried));
      chk("fill_level",    128'(fill_level),    128'(e.fill));
`ifdef MATCHER_MULTI_HIT_EN
      chk("hit_count",     128'(hit_count),     128'(e.hits));
`endif
    end
  end

  initial begin
    reset = 1; target_load = 0; target_in = '0; cand_valid = 0; cand_in = '0;
    dig_valid = 0; dig_in = '0;

    // reset state, then two non-matching digests
    cyc(1, 0, '0, 0, '0, 0, '0);
    cyc(1, 0, '0, 0, '0, 0, '0);
    load(TGT);
    push("aaaa");
    push("aaab");
    dig(128'h1);
    dig(128'h2);
    idle();

    // matching digest on "a99a"
    push("a99a");
    dig(TGT);
    idle();
    push("zzzz");
    dig(128'h5);

    // fill to DEPTH, refused extra push, push+pop while full
    load(TGT);
    for (int i = 0; i < DEPTH; i++) push(128'(i + 100));
    push(128'h999);
    cyc(0, 0, '0, 1, 128'h777, 1, 128'h3);
    idle();

    // underflow then clear by target_load
    load(TGT);
    dig(128'h4);
    idle();
    load(TGT);

    // reset with outstanding candidates
    push("c001"); push("c002"); push("c003");
    cyc(1, 0, '0, 0, '0, 0, '0);
    idle();

    // two matches three cycles apart
    load(TGT);
    push("m001");
    push("m002");
    dig(TGT);
    idle(); idle();
    dig(TGT);
    idle();

    // target_load racing a digest, and an empty-FIFO push with digest
    push("r001");
    cyc(0, 1, TGT, 0, '0, 1, TGT);
    cyc(0, 0, '0, 1, "r002", 1, TGT);
    idle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic rst, tl, cv, dv;
      logic [127:0] tin, c, d;
      rst = ($urandom_range(0, 99) == 0);
      tl  = ($urandom_range(0, 39) == 0);
      tin = ($urandom_range(0, 3) == 0) ? TGT2 : TGT;
      cv  = ($urandom_range(0, 9) < 6);
      c   = {$urandom, $urandom, $urandom, $urandom};
      dv  = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 7))
        0:       d = TGT;
        1:       d = TGT2;
        default: d = {$urandom, $urandom, $urandom, $urandom};
      endcase
      cyc(rst, tl, tin, cv, c, dv, d);
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
